// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the 640x480@60 mode, the frame/line total
// helper, and the packed bundle of sync/enable bits that travels through the
// aligned output pipeline.
// ---------------------------------------------------------------------------
package vga_pkg;

    // 640x480@60 horizontal timing (pixels)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // 640x480@60 vertical timing (lines)
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Total length of a line or a frame: active + front porch + sync + back porch
    function automatic int vga_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // Sync/enable bits carried through the delay line (polarity already applied)
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_sync_t;

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Parametrised shift register: DEPTH stages of WIDTH bits, advancing only when
// en is high, every stage loaded with RST_VAL while reset is high.
// DEPTH = 0 degenerates to a wire.
// Ports:
//   pclk   - clock
//   reset  - synchronous active-high reset
//   en     - shift enable
//   din    - data into stage 0
//   dout   - data out of the last stage
// ---------------------------------------------------------------------------
module vga_delay_line #(
    parameter int                 WIDTH   = 1,
    parameter int                 DEPTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift register: reset fills every stage with the idle value
            always_ff @(posedge pclk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else if (en) begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_pipe_driver.sv
// ---------------------------------------------------------------------------
// vga_pipe_driver
// VGA timing generator with a fetch-latency-aligned output pipeline.
// Stage 0 (the counters) issues pixel coordinates to an external memory; the
// returned colour arrives FETCH_LAT enabled cycles later and is registered
// together with hsync/vsync/de, so the colour for (x,y) leaves in the same
// cycle as de for (x,y).
// Ports:
//   pclk, reset        - clock, synchronous active-high reset
//   pix_en             - pixel advance enable
//   vga_data           - {r,g,b} from memory, FETCH_LAT cycles after address
//   h_addr, v_addr     - stage-0 visible coordinates (0 outside active area)
//   addr_valid         - stage-0 coordinates are visible
//   line_start         - pulse on the first enabled cycle of each line
//   frame_start        - pulse on the first enabled cycle of each frame
//   hsync, vsync, de   - registered, aligned to vga_r/g/b
//   vga_r, vga_g, vga_b- registered colour, forced to 0 while blanking
// ---------------------------------------------------------------------------
module vga_pipe_driver
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = VGA_H_ACTIVE,
    parameter int   H_FP      = VGA_H_FP,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BP      = VGA_H_BP,
    parameter int   V_ACTIVE  = VGA_V_ACTIVE,
    parameter int   V_FP      = VGA_V_FP,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BP      = VGA_V_BP,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   FETCH_LAT = 2,
    parameter int   CW        = 4,
    parameter int   AW        = 10
) (
    input  logic            pclk,
    input  logic            reset,
    input  logic            pix_en,
    input  logic [3*CW-1:0] vga_data,
    output logic [AW-1:0]   h_addr,
    output logic [AW-1:0]   v_addr,
    output logic            addr_valid,
    output logic            line_start,
    output logic            frame_start,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic [CW-1:0]   vga_r,
    output logic [CW-1:0]   vga_g,
    output logic [CW-1:0]   vga_b
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    // Region boundaries sized to the counters so comparisons stay width-matched
    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] H_ONE      = {{(HCW-1){1'b0}}, 1'b1};
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] V_ONE      = {{(VCW-1){1'b0}}, 1'b1};

    localparam vga_sync_t SYNC_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    logic [HCW-1:0] h_cnt_r;
    logic [VCW-1:0] v_cnt_r;
    logic           h_act_s;
    logic           v_act_s;
    logic           h_sync_s;
    logic           v_sync_s;
    vga_sync_t      sync0_s;
    vga_sync_t      sync_dly_s;

    // Raster counters: h wraps at H_TOTAL-1 and carries into v on the same cycle
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt_r <= {HCW{1'b0}};
            v_cnt_r <= {VCW{1'b0}};
        end else if (pix_en) begin
            if (h_cnt_r == H_LAST) begin
                h_cnt_r <= {HCW{1'b0}};
                if (v_cnt_r == V_LAST) begin
                    v_cnt_r <= {VCW{1'b0}};
                end else begin
                    v_cnt_r <= v_cnt_r + V_ONE;
                end
            end else begin
                h_cnt_r <= h_cnt_r + H_ONE;
            end
        end
    end

    // Stage-0 region decode and coordinate outputs
    always_comb begin
        h_act_s  = (h_cnt_r < H_ACT_END);
        v_act_s  = (v_cnt_r < V_ACT_END);
        h_sync_s = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_END);
        v_sync_s = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_END);

        addr_valid = h_act_s && v_act_s;
        if (addr_valid) begin
            h_addr = AW'(h_cnt_r);
            v_addr = AW'(v_cnt_r);
        end else begin
            h_addr = {AW{1'b0}};
            v_addr = {AW{1'b0}};
        end

        line_start  = pix_en && (h_cnt_r == {HCW{1'b0}});
        frame_start = line_start && (v_cnt_r == {VCW{1'b0}});

        // Polarity is applied here so idle values in the pipe are already final
        sync0_s.hs = h_sync_s ? HS_POL : ~HS_POL;
        sync0_s.vs = v_sync_s ? VS_POL : ~VS_POL;
        sync0_s.de = addr_valid;
    end

    // FETCH_LAT stages line sync/de up with the returning vga_data
    vga_delay_line #(
        .WIDTH   ($bits(vga_sync_t)),
        .DEPTH   (FETCH_LAT),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .pclk  (pclk),
        .reset (reset),
        .en    (pix_en),
        .din   (sync0_s),
        .dout  (sync_dly_s)
    );

    // Final output stage: sync/de plus colour, colour blanked when de is low
    always_ff @(posedge pclk) begin
        if (reset) begin
            hsync <= SYNC_IDLE.hs;
            vsync <= SYNC_IDLE.vs;
            de    <= SYNC_IDLE.de;
            vga_r <= {CW{1'b0}};
            vga_g <= {CW{1'b0}};
            vga_b <= {CW{1'b0}};
        end else if (pix_en) begin
            hsync <= sync_dly_s.hs;
            vsync <= sync_dly_s.vs;
            de    <= sync_dly_s.de;
            if (sync_dly_s.de) begin
                vga_r <= vga_data[3*CW-1:2*CW];
                vga_g <= vga_data[2*CW-1:CW];
                vga_b <= vga_data[CW-1:0];
            end else begin
                vga_r <= {CW{1'b0}};
                vga_g <= {CW{1'b0}};
                vga_b <= {CW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_vga_pipe_driver.sv
// ---------------------------------------------------------------------------
// tb_vga_pipe_driver
// Small raster (15 x 8 total, 8 x 4 visible) so whole frames fit in a short
// run. Layout: H active 0..7, FP 8..9, sync 10..12, BP 13..14;
//              V active 0..3, FP 4, sync 5..6, BP 7.
// A two-stage memory model returns {h_addr[3:0], v_addr[3:0], 4'h5}.
// Rows are {phase, cycle after reset release, expected outputs}.
// ---------------------------------------------------------------------------
module tb_vga_pipe_driver;

    localparam int CW = 4;
    localparam int AW = 10;

    logic            pclk;
    logic            reset;
    logic            pix_en;
    logic [3*CW-1:0] vga_data;
    logic [AW-1:0]   h_addr;
    logic [AW-1:0]   v_addr;
    logic            addr_valid;
    logic            line_start;
    logic            frame_start;
    logic            hsync;
    logic            vsync;
    logic            de;
    logic [CW-1:0]   vga_r;
    logic [CW-1:0]   vga_g;
    logic [CW-1:0]   vga_b;

    logic            force_fff;
    logic [11:0]     mem_d1;
    logic [11:0]     mem_d2;

    int n_vec;
    int n_bad;

    typedef struct {
        int          ph;
        int          k;
        logic [37:0] exp;
    } vec_t;

    vec_t tbl[$];

    vga_pipe_driver #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b0), .VS_POL (1'b0),
        .FETCH_LAT (2), .CW (CW), .AW (AW)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .pix_en      (pix_en),
        .vga_data    (vga_data),
        .h_addr      (h_addr),
        .v_addr      (v_addr),
        .addr_valid  (addr_valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Two-cycle memory, advancing on the same enabled cycles as the DUT
    always @(posedge pclk) begin
        if (pix_en) begin
            mem_d1 <= {h_addr[3:0], v_addr[3:0], 4'h5};
            mem_d2 <= mem_d1;
        end
    end

    assign vga_data = force_fff ? 12'hFFF : mem_d2;

    function automatic logic [37:0] pack(input int h, input int v,
                                         input logic av, input logic ls, input logic fs,
                                         input logic hs, input logic vs, input logic d,
                                         input logic [11:0] rgb);
        logic [9:0] hh;
        logic [9:0] vv;
        hh = 10'(h);
        vv = 10'(v);
        return {hh, vv, av, ls, fs, hs, vs, d, rgb};
    endfunction

    task automatic add(input int ph, input int k, input int h, input int v,
                       input logic av, input logic ls, input logic fs,
                       input logic hs, input logic vs, input logic d,
                       input logic [11:0] rgb);
        vec_t r;
        r.ph  = ph;
        r.k   = k;
        r.exp = pack(h, v, av, ls, fs, hs, vs, d, rgb);
        tbl.push_back(r);
    endtask

    task automatic check(input string name, input logic [37:0] exp);
        logic [37:0] got;
        got = {h_addr, v_addr, addr_valid, line_start, frame_start,
               hsync, vsync, de, vga_r, vga_g, vga_b};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got h=%0d v=%0d av/ls/fs=%b%b%b hs/vs/de=%b%b%b rgb=%h, expected h=%0d v=%0d av/ls/fs=%b%b%b hs/vs/de=%b%b%b rgb=%h",
                     name, got[37:28], got[27:18], got[17], got[16], got[15],
                     got[14], got[13], got[12], got[11:0],
                     exp[37:28], exp[27:18], exp[17], exp[16], exp[15],
                     exp[14], exp[13], exp[12], exp[11:0]);
        end
    endtask

    // Reset, check the reset state, then step cycles 0..last_k comparing table rows
    task automatic run_phase(input int ph, input int last_k);
        @(negedge pclk);
        reset     = 1'b1;
        pix_en    = 1'b1;
        force_fff = (ph == 2);
        repeat (3) @(negedge pclk);
        #1;
        check($sformatf("ph%0d_reset", ph), pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000));
        for (int k = 0; k <= last_k; k++) begin
            reset  = 1'b0;
            pix_en = (ph == 1) ? (k % 2 == 0) : 1'b1;
            #1;
            foreach (tbl[i]) begin
                if (tbl[i].ph == ph && tbl[i].k == k) begin
                    check($sformatf("ph%0d_k%0d", ph, k), tbl[i].exp);
                end
            end
            @(negedge pclk);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        pix_en    = 1'b1;
        force_fff = 1'b0;

        // Phase 0: pix_en=1, memory model data; outputs lag stage 0 by 3 cycles
        //      ph k    h  v  av ls fs hs vs de rgb
        add(0,   0,  0, 0, 1, 1, 1, 1, 1, 0, 12'h000);
        add(0,   1,  1, 0, 1, 0, 0, 1, 1, 0, 12'h000);
        add(0,   3,  3, 0, 1, 0, 0, 1, 1, 1, 12'h005);
        add(0,   5,  5, 0, 1, 0, 0, 1, 1, 1, 12'h205);
        add(0,   8,  0, 0, 0, 0, 0, 1, 1, 1, 12'h505);
        add(0,  10,  0, 0, 0, 0, 0, 1, 1, 1, 12'h705);
        add(0,  11,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(0,  13,  0, 0, 0, 0, 0, 0, 1, 0, 12'h000);
        add(0,  15,  0, 1, 1, 1, 0, 0, 1, 0, 12'h000);
        add(0,  16,  1, 1, 1, 0, 0, 1, 1, 0, 12'h000);
        add(0,  18,  3, 1, 1, 0, 0, 1, 1, 1, 12'h015);
        add(0,  22,  7, 1, 1, 0, 0, 1, 1, 1, 12'h415);
        add(0,  55,  0, 0, 0, 0, 0, 1, 1, 1, 12'h735);
        add(0,  56,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(0,  62,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(0,  77,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(0,  78,  0, 0, 0, 0, 0, 1, 0, 0, 12'h000);
        add(0, 107,  0, 0, 0, 0, 0, 1, 0, 0, 12'h000);
        add(0, 108,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(0, 120,  0, 0, 1, 1, 1, 0, 1, 0, 12'h000);
        add(0, 123,  3, 0, 1, 0, 0, 1, 1, 1, 12'h005);
        // Phase 1: pix_en high on even cycles only; state frozen on odd cycles
        add(1,   0,  0, 0, 1, 1, 1, 1, 1, 0, 12'h000);
        add(1,   1,  1, 0, 1, 0, 0, 1, 1, 0, 12'h000);
        add(1,   5,  3, 0, 1, 0, 0, 1, 1, 1, 12'h005);
        add(1,   6,  3, 0, 1, 0, 0, 1, 1, 1, 12'h005);
        add(1,   7,  4, 0, 1, 0, 0, 1, 1, 1, 12'h105);
        add(1,  29,  0, 1, 1, 0, 0, 0, 1, 0, 12'h000);
        add(1,  30,  0, 1, 1, 1, 0, 0, 1, 0, 12'h000);
        add(1,  31,  1, 1, 1, 0, 0, 1, 1, 0, 12'h000);
        // Phase 2: vga_data stuck at 12'hFFF; colour must blank outside de
        add(2,   3,  3, 0, 1, 0, 0, 1, 1, 1, 12'hFFF);
        add(2,   8,  0, 0, 0, 0, 0, 1, 1, 1, 12'hFFF);
        add(2,  11,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);
        add(2,  13,  0, 0, 0, 0, 0, 0, 1, 0, 12'h000);
        add(2,  63,  0, 0, 0, 0, 0, 1, 1, 0, 12'h000);

        run_phase(0, 123);
        run_phase(1, 31);
        run_phase(2, 63);

        // Phase 3: reset in the middle of the picture (h=5, v=2)
        run_phase(3, 34);
        reset  = 1'b1;
        pix_en = 1'b1;
        #1;
        check("mid_before_reset", pack(5, 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h225));
        @(negedge pclk);
        reset  = 1'b0;
        pix_en = 1'b0;
        #1;
        check("mid_after_reset", pack(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000));
        @(negedge pclk);
        pix_en = 1'b0;
        #1;
        check("mid_idle_hold", pack(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000));
        @(negedge pclk);
        pix_en = 1'b1;
        #1;
        check("mid_first_enabled", pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000));
        @(negedge pclk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_pipe_driver.md
VGA_PIPE_DRIVER -- requirements
Module: vga_pipe_driver

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, the vertical equivalents in lines.
REQ-006 SHALL have parameters HS_POL and VS_POL, both default 0, giving the active sync level (0 = active-low).
REQ-007 SHALL have parameter FETCH_LAT, default 2, range 0..8, the cycles from address out to vga_data valid.
REQ-008 SHALL have parameter CW, default 4, bits per colour channel.
REQ-009 SHALL have parameter AW, default 10, width of h_addr and v_addr.
REQ-010 SHALL have port pclk, input, 1, the single clock.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port pix_en, input, 1, pixel-advance enable (tie high for a native pixel clock).
REQ-013 SHALL have port vga_data, input, 3*CW, pixel colour {r,g,b}, valid FETCH_LAT cycles after its address.
REQ-014 SHALL have ports h_addr and v_addr, output, AW each, active-pixel coordinates; 0 when not active.
REQ-015 SHALL have port addr_valid, output, 1, high when h_addr/v_addr denote a visible pixel.
REQ-016 SHALL have ports line_start and frame_start, output, 1 each, single-cycle pulses.
REQ-017 SHALL have ports hsync, vsync and de, output, 1 each, sync pulses and data-enable, aligned to the colour outputs.
REQ-018 SHALL have ports vga_r, vga_g and vga_b, output, CW each, registered colour outputs.

Function
REQ-019 Counter h_cnt SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), advancing only on cycles with pix_en=1.
REQ-020 Counter v_cnt SHALL increment when h_cnt wraps, and wrap 0 after V_TOTAL-1 on the same enabled cycle.
REQ-021 Line region order SHALL be active, FP, sync, BP (hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)); vertical likewise.
REQ-022 h_addr, v_addr and addr_valid SHALL be combinational from the counters (stage 0, zero latency).
REQ-023 line_start SHALL equal pix_en & (h_cnt==0); frame_start SHALL equal pix_en & (h_cnt==0) & (v_cnt==0).
REQ-024 hsync, vsync and de SHALL be the stage-0 values delayed by exactly FETCH_LAT+1 enabled cycles, with polarity applied.
REQ-025 The colour registers SHALL load vga_data when the FETCH_LAT-delayed de is 1, and 0 otherwise, on enabled cycles only.
REQ-026 Result: the colour for address (x,y) SHALL appear on vga_r/g/b in the same cycle de is asserted for (x,y).
REQ-027 When pix_en=0, all counters, the delay line and the output registers SHALL hold their values.
REQ-028 Colour outputs SHALL be 0 whenever de=0 (blanking is enforced regardless of vga_data).

Reset
REQ-029 While reset=1, h_cnt and v_cnt SHALL be cleared to 0 and all delay stages filled with the idle values.
REQ-030 Idle values SHALL be: hsync=~HS_POL, vsync=~VS_POL, de=0, colour outputs 0.
REQ-031 Reset SHALL take priority over pix_en.
REQ-032 After reset is released, the first enabled cycle SHALL assert frame_start.

Structure
REQ-033 Package vga_pkg SHALL hold the 640x480@60 timing constants and the derived H_TOTAL/V_TOTAL function.
REQ-034 The aligned pipeline SHALL use one sub-module, vga_delay_line: a parametrised width/depth shift register with enable and reset value.

Verification
REQ-035 Defaults, pix_en=1: hsync low for exactly 96 cycles per line, with an 800-cycle period; first low at 659 cycles after line_start (656+3).
REQ-036 Defaults: frame_start period 420000 cycles; vsync low for exactly 2 lines, starting at line 490; de high for 640 cycles on each of 480 lines.
REQ-037 FETCH_LAT=2 with a 2-cycle memory model returning {h_addr[3:0],v_addr[3:0],4'h5}: every de=1 cycle shows matching coordinates on r/g.
REQ-038 vga_data held at 12'hFFF: vga_r/g/b=0 on every de=0 cycle and 4'hF on every de=1 cycle.
REQ-039 pix_en toggling 1/0: line period 1600 cycles, with outputs frozen on pix_en=0 cycles.
REQ-040 Reset asserted at h_cnt=300, v_cnt=200: next cycle h_addr=0, de=0, hsync/vsync idle; frame_start on the first enabled cycle after release.
